// File: rtl/frontend.sv
// Instruction fetch frontend: PC register, i-cache handshake, branch prediction.
// Define FRONTEND_BPRED_EN to build the 2-bit counter + BTB predictor.
module frontend #(
    parameter int              XLEN         = 32,
    parameter int              ILEN         = 32,
    parameter int              HLEN         = 4,
    parameter int              ICACHE_INSTR = 4,
    parameter logic [XLEN-1:0] BOOT_PC      = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flush_i,
    output logic [XLEN-1:0]              addr_o,
    output logic                         addr_valid_o,
    input  logic                         addr_ready_i,
    input  logic [XLEN-1:0]              data_pc_i,
    input  logic [ICACHE_INSTR*ILEN-1:0] data_line_i,
    input  logic                         data_valid_i,
    output logic                         data_ready_o,
    input  logic                         issue_ready_i,
    output logic                         issue_valid_o,
    output logic [ILEN-1:0]              instruction_o,
    output logic [XLEN-1:0]              pred_pc_o,
    output logic [HLEN-1:0]              pred_index_o,
    output logic [XLEN-1:0]              pred_target_o,
    output logic                         pred_taken_o,
    input  logic                         res_valid_i,
    input  logic                         res_taken_i,
    input  logic                         res_mispredict_i,
    input  logic [XLEN-1:0]              res_pc_i,
    input  logic [XLEN-1:0]              res_target_i,
    input  logic [HLEN-1:0]              res_index_i,
    output logic [XLEN-1:0]              pc_o
);

    localparam int SLOTW = (ICACHE_INSTR > 1) ? $clog2(ICACHE_INSTR) : 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  pc_plus4;
    logic [SLOTW-1:0] slot;
    logic [HLEN-1:0]  idx;
    logic             match;
    logic             redirect;
    logic             fetch_ok;
    logic             hit;
    logic [XLEN-1:0]  btb_tgt;
    logic             ctr_taken;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign idx      = pc_q[HLEN+1:2];
    assign slot     = (ICACHE_INSTR > 1) ? pc_q[SLOTW+1:2] : '0;

`ifdef FRONTEND_BPRED_EN
    localparam int DEPTH = 1 << HLEN;
    localparam int TAGW  = XLEN - HLEN - 2;

    logic [1:0]      ctr_q     [DEPTH];
    logic [1:0]      ctr_d     [DEPTH];
    logic            btb_v_q   [DEPTH];
    logic            btb_v_d   [DEPTH];
    logic [TAGW-1:0] btb_tag_q [DEPTH];
    logic [TAGW-1:0] btb_tag_d [DEPTH];
    logic [XLEN-1:0] btb_tgt_q [DEPTH];
    logic [XLEN-1:0] btb_tgt_d [DEPTH];

    // Lookup reads registered state, so a same-cycle update is seen next cycle.
    assign hit       = btb_v_q[idx] & (btb_tag_q[idx] == pc_q[XLEN-1:HLEN+2]);
    assign btb_tgt   = btb_tgt_q[idx];
    assign ctr_taken = ctr_q[idx][1];

    always_comb begin
        ctr_d     = ctr_q;
        btb_v_d   = btb_v_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        if (res_valid_i) begin
            if (res_taken_i && ctr_q[res_index_i] != 2'b11) begin
                ctr_d[res_index_i] = ctr_q[res_index_i] + 2'b01;
            end else if (!res_taken_i && ctr_q[res_index_i] != 2'b00) begin
                ctr_d[res_index_i] = ctr_q[res_index_i] - 2'b01;
            end
            if (res_taken_i) begin
                btb_v_d[res_index_i]   = 1'b1;
                btb_tag_d[res_index_i] = res_pc_i[XLEN-1:HLEN+2];
                btb_tgt_d[res_index_i] = res_target_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i]   <= 2'b01;
                btb_v_q[i] <= 1'b0;
            end
        end else begin
            ctr_q   <= ctr_d;
            btb_v_q <= btb_v_d;
        end
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end
`else
    logic unused_res_index;

    assign unused_res_index = ^res_index_i;
    assign hit              = 1'b0;
    assign btb_tgt          = pc_plus4;
    assign ctr_taken        = 1'b0;
`endif

    assign match    = data_valid_i & (data_pc_i == pc_q);
    assign redirect = res_valid_i & res_mispredict_i;
    assign fetch_ok = addr_valid_o & addr_ready_i & match
                    & issue_ready_i & ~redirect;

    assign addr_valid_o  = rst_n_i & ~flush_i;
    assign data_ready_o  = issue_ready_i;
    assign issue_valid_o = fetch_ok;
    assign instruction_o = data_line_i[int'(slot)*ILEN +: ILEN];
    assign pc_o          = pc_q;
    assign addr_o        = pc_q;
    assign pred_pc_o     = pc_q;
    assign pred_index_o  = idx;
    assign pred_taken_o  = fetch_ok & hit & ctr_taken;
    assign pred_target_o = hit ? btb_tgt : pc_plus4;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = res_taken_i ? res_target_i : res_pc_i + XLEN'(4);
        end else if (fetch_ok) begin
            pc_d = pred_taken_o ? pred_target_o : pc_plus4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q <= BOOT_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_frontend.sv
// Randomized bench for frontend against a table-based reference model.
// Predictor expectations follow FRONTEND_BPRED_EN when it is defined.
module tb_frontend;

    localparam int          NI    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BOOT  = 32'h0;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst_n_i, flush_i, addr_ready_i, data_valid_i;
    logic         issue_ready_i, res_valid_i, res_taken_i, res_mispredict_i;
    logic [31:0]  data_pc_i, res_pc_i, res_target_i;
    logic [127:0] data_line_i;
    logic [3:0]   res_index_i;
    logic [31:0]  addr_o, pred_pc_o, pred_target_o, pc_o;
    logic [31:0]  instruction_o;
    logic [3:0]   pred_index_o;
    logic         addr_valid_o, data_ready_o, issue_valid_o, pred_taken_o;

    always #5 clk = ~clk;

    frontend #(
        .XLEN(32), .ILEN(32), .HLEN(4), .ICACHE_INSTR(NI), .BOOT_PC(BOOT)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .addr_o(addr_o), .addr_valid_o(addr_valid_o),
        .addr_ready_i(addr_ready_i), .data_pc_i(data_pc_i),
        .data_line_i(data_line_i), .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o), .issue_ready_i(issue_ready_i),
        .issue_valid_o(issue_valid_o), .instruction_o(instruction_o),
        .pred_pc_o(pred_pc_o), .pred_index_o(pred_index_o),
        .pred_target_o(pred_target_o), .pred_taken_o(pred_taken_o),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i),
        .res_mispredict_i(res_mispredict_i), .res_pc_i(res_pc_i),
        .res_target_i(res_target_i), .res_index_i(res_index_i),
        .pc_o(pc_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc;
    int          m_ctr  [DEPTH];
    bit          m_bv   [DEPTH];
    logic [31:0] m_btag [DEPTH];
    logic [31:0] m_btgt [DEPTH];
    bit          echo = 1'b1;

    task automatic model_reset();
        m_pc = BOOT;
        for (int i = 0; i < DEPTH; i++) begin
            m_ctr[i] = 1;
            m_bv[i]  = 1'b0;
        end
    endtask

    // One clock: check combinational outputs, then advance the model.
    task automatic step();
        logic [31:0] p4, ptgt, nxt, rpc, rtgt;
        logic        ok, hit, pt, rv, rt, rst;
        int          idx, w, ridx;
        if (echo) data_pc_i = m_pc;
        @(negedge clk);
        idx = int'((m_pc >> 2) % DEPTH);
        w   = int'((m_pc >> 2) % NI);
        p4  = m_pc + 32'd4;
        ok  = rst_n_i && !flush_i && addr_ready_i && data_valid_i
              && data_pc_i == m_pc && issue_ready_i
              && !(res_valid_i && res_mispredict_i);
`ifdef FRONTEND_BPRED_EN
        hit = m_bv[idx] && m_btag[idx] == (m_pc >> 6);
`else
        hit = 1'b0;
`endif
        ptgt = hit ? m_btgt[idx] : p4;
        pt   = ok && hit && m_ctr[idx] >= 2;
        check("pc_o", pc_o, m_pc);
        check("addr_o", addr_o, m_pc);
        check("pred_pc", pred_pc_o, m_pc);
        check("addr_valid", addr_valid_o, rst_n_i && !flush_i);
        check("data_ready", data_ready_o, issue_ready_i);
        check("issue_valid", issue_valid_o, ok);
        check("instr", instruction_o, data_line_i[w*32 +: 32]);
        check("pred_index", pred_index_o, idx);
        check("pred_taken", pred_taken_o, pt);
        check("pred_target", pred_target_o, ptgt);
        if (res_valid_i && res_mispredict_i)
            nxt = res_taken_i ? res_target_i : res_pc_i + 32'd4;
        else if (ok)
            nxt = pt ? ptgt : p4;
        else
            nxt = m_pc;
        rst  = !rst_n_i;
        rv   = res_valid_i;
        rt   = res_taken_i;
        rpc  = res_pc_i;
        rtgt = res_target_i;
        ridx = int'(res_index_i);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_pc = nxt;
            if (rv) begin
                if (rt && m_ctr[ridx] < 3) m_ctr[ridx]++;
                if (!rt && m_ctr[ridx] > 0) m_ctr[ridx]--;
                if (rt) begin
                    m_bv[ridx]   = 1'b1;
                    m_btag[ridx] = rpc >> 6;
                    m_btgt[ridx] = rtgt;
                end
            end
        end
    endtask

    task automatic resolve(logic t, logic mp, logic [31:0] pc,
                           logic [31:0] tgt, logic [3:0] ix);
        res_valid_i      = 1'b1;
        res_taken_i      = t;
        res_mispredict_i = mp;
        res_pc_i         = pc;
        res_target_i     = tgt;
        res_index_i      = ix;
        step();
        res_valid_i      = 1'b0;
        res_mispredict_i = 1'b0;
    endtask

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; addr_ready_i = 1'b0;
        data_valid_i = 1'b1; issue_ready_i = 1'b1;
        res_valid_i = 1'b0; res_taken_i = 1'b0; res_mispredict_i = 1'b0;
        res_pc_i = '0; res_target_i = '0; res_index_i = '0;
        data_pc_i = '0;
        data_line_i = {NOP, NOP, NOP, NOP};
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_pc", pc_o, BOOT);
        check("rst_addr_valid", addr_valid_o, 1'b0);
        check("rst_issue", issue_valid_o, 1'b0);
        step();
        rst_n_i = 1'b1;

        repeat (6) step();
        check("ready_low_pc", pc_o, 32'h0);

        addr_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("seq_pc", pc_o, 32'(i * 4));
            step();
        end
        issue_ready_i = 1'b0;
        repeat (3) step();
        data_pc_i = m_pc;
        #1;
        check("stall_pc", pc_o, 32'h8);
        check("stall_issue", issue_valid_o, 1'b0);
        issue_ready_i = 1'b1;
        step();
        check("resume_pc", pc_o, 32'hC);
        check("resume_instr", instruction_o, NOP);
        step();
        check("seq_pc10", pc_o, 32'h10);

        issue_ready_i = 1'b0;
        resolve(1'b1, 1'b1, 32'h0, 32'h100, 4'h0);
        check("misp_taken", pc_o, 32'h100);
        resolve(1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
        check("misp_ntaken", pc_o, 32'h44);

        resolve(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC, 4'h1);
        issue_ready_i = 1'b1;
        step();
        check("wrap_pc", pc_o, 32'h0);

        issue_ready_i = 1'b0;
        resolve(1'b1, 1'b0, 32'h20, 32'h80, 4'h8);
        resolve(1'b1, 1'b0, 32'h20, 32'h80, 4'h8);
        resolve(1'b1, 1'b1, 32'h200, 32'h20, 4'h0);
        issue_ready_i = 1'b1;
        data_pc_i = m_pc;
        #1;
`ifdef FRONTEND_BPRED_EN
        check("bp_taken", pred_taken_o, 1'b1);
        check("bp_target", pred_target_o, 32'h80);
        step();
        check("bp_next_pc", pc_o, 32'h80);
`else
        check("bp_off_taken", pred_taken_o, 1'b0);
        check("bp_off_target", pred_target_o, 32'h24);
        step();
        check("bp_off_next_pc", pc_o, 32'h24);
`endif

        flush_i = 1'b1;
        #1;
        check("flush_addr_valid", addr_valid_o, 1'b0);
        check("flush_issue", issue_valid_o, 1'b0);
        repeat (2) step();
`ifdef FRONTEND_BPRED_EN
        check("flush_pc", pc_o, 32'h80);
`else
        check("flush_pc", pc_o, 32'h24);
`endif
        flush_i = 1'b0;

        for (int i = 0; i < 800; i++) begin
            rst_n_i          = $urandom_range(0, 99) != 0;
            flush_i          = $urandom_range(0, 15) == 0;
            addr_ready_i     = $urandom_range(0, 3) != 0;
            issue_ready_i    = $urandom_range(0, 3) != 0;
            data_valid_i     = $urandom_range(0, 7) != 0;
            echo             = $urandom_range(0, 7) != 0;
            if (!echo) data_pc_i = m_pc + 32'($urandom_range(0, 2)) * 4;
            data_line_i      = {$urandom, $urandom, $urandom, $urandom};
            res_valid_i      = $urandom_range(0, 2) == 0;
            res_taken_i      = 1'($urandom_range(0, 1));
            res_mispredict_i = $urandom_range(0, 5) == 0;
            res_pc_i         = $urandom_range(0, 1) != 0 ? m_pc
                               : 32'($urandom_range(0, 63)) << 2;
            res_target_i     = 32'($urandom_range(0, 63)) << 2;
            res_index_i      = $urandom_range(0, 7) != 0 ? res_pc_i[5:2]
                               : 4'($urandom_range(0, 15));
            step();
        end
        echo = 1'b1;
        flush_i = 1'b0;
        rst_n_i = 1'b1;

        issue_ready_i = 1'b0;
        resolve(1'b1, 1'b1, 32'h0, 32'h300, 4'h2);
        rst_n_i = 1'b0;
        res_valid_i = 1'b1;
        res_mispredict_i = 1'b1;
        res_taken_i = 1'b1;
        res_target_i = 32'h500;
        #1;
        check("midrst_addr_valid", addr_valid_o, 1'b0);
        check("midrst_pred_taken", pred_taken_o, 1'b0);
        step();
        res_valid_i = 1'b0;
        res_mispredict_i = 1'b0;
        check("midrst_pc", pc_o, BOOT);
        rst_n_i = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frontend.md
FRONTEND -- requirements
Module: frontend

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width.
REQ-003 SHALL have parameter HLEN, default 4, predictor index width (2^HLEN table entries).
REQ-004 SHALL have parameter ICACHE_INSTR, default 4, instructions per i-cache line (power of 2).
REQ-005 SHALL have parameter BOOT_PC, default 32'h0000_0000, PC after reset.
REQ-006 SHALL have one clock and a synchronous, active-low reset: clk_i  in  1  clock, all state on rising edge; rst_n_i  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: flush_i  in  1  discard current fetch.
REQ-008 SHALL have ports: addr_o  out  XLEN  i-cache request address; addr_valid_o  out  1; addr_ready_i  in  1.
REQ-009 SHALL have ports: data_pc_i  in  XLEN  PC of returned line; data_line_i  in  ICACHE_INSTR*ILEN  line, instruction 0 in LSBs; data_valid_i  in  1; data_ready_o  out  1.
REQ-010 SHALL have ports: issue_ready_i  in  1; issue_valid_o  out  1; instruction_o  out  ILEN; pred_pc_o  out  XLEN; pred_index_o  out  HLEN; pred_target_o  out  XLEN; pred_taken_o  out  1.
REQ-011 SHALL have ports: res_valid_i, res_taken_i, res_mispredict_i  in  1; res_pc_i, res_target_i  in  XLEN; res_index_i  in  HLEN (branch resolution from execute).
REQ-012 SHALL have port pc_o  out  XLEN  current fetch PC.

Function
REQ-013 SHALL hold PC register pc; pc_o = addr_o = pred_pc_o = pc.
REQ-014 SHALL drive addr_valid_o = rst_n_i & ~flush_i; data_ready_o = issue_ready_i.
REQ-015 SHALL define match = data_valid_i & (data_pc_i == pc); fetch_ok = addr_valid_o & addr_ready_i & match & issue_ready_i & ~(res_valid_i & res_mispredict_i).
REQ-016 SHALL drive issue_valid_o = fetch_ok, combinationally, zero-latency from i-cache response.
REQ-017 SHALL drive instruction_o = data_line_i slot pc[$clog2(ICACHE_INSTR)+1:2] (ILEN bits).
REQ-018 SHALL compute pred_index_o = pc[HLEN+1:2].
REQ-019 SHALL keep 2^HLEN 2-bit saturating counters and 2^HLEN BTB entries {valid, tag = pc[XLEN-1:HLEN+2], target}.
REQ-020 SHALL assert pred_taken_o = fetch_ok & BTB hit at index & counter >= 2; pred_target_o = BTB target on hit, else pc+4.
REQ-021 SHALL update next PC, priority: (a) res_valid_i & res_mispredict_i -> res_taken_i ? res_target_i : res_pc_i+4, regardless of stall/flush; (b) fetch_ok -> pred_taken_o ? pred_target_o : pc+4; (c) else hold.
REQ-022 SHALL on res_valid_i increment (taken) or decrement (not taken) counter[res_index_i], saturating at 3/0.
REQ-023 SHALL on res_valid_i & res_taken_i write BTB[res_index_i] = {1, res_pc_i tag, res_target_i}.
REQ-024 SHALL let same-cycle table update and lookup at same index return the old (pre-update) contents.
REQ-025 SHALL wrap PC modulo 2^XLEN (pc+4 at 32'hFFFF_FFFC gives 0).
REQ-026 SHALL treat X/0 on addr_ready_i as not-ready; no issue while low.

Reset
REQ-027 SHALL, when rst_n_i low at a clock edge, set pc = BOOT_PC, all counters = 2'b01, all BTB valid = 0.
REQ-028 SHALL, while rst_n_i low, force addr_valid_o = issue_valid_o = pred_taken_o = 0; reset mid-operation discards any pending redirect.

Configuration
REQ-029 SHALL use macro FRONTEND_BPRED_EN: defined -> predictor per REQ-019..024; undefined -> no tables, pred_taken_o = 0, pred_target_o = pc+4, pred_index_o as REQ-018, res_* used only for mispredict redirect.

Verification
REQ-030 Reset, BOOT_PC=0, echo i-cache (data_pc_i=addr_o, NOP line, valid=1), addr_ready_i=0 for 6 cycles -> pc stays 0, issue_valid_o=0.
REQ-031 Then addr_ready_i=1, issue_ready_i=1 -> pc 0,4,8,C,10 on consecutive cycles, instruction_o=32'h00000013 each cycle.
REQ-032 issue_ready_i=0 at pc=8 for 3 cycles -> pc holds 8, issue_valid_o=0; resumes to C.
REQ-033 res_valid=1, mispredict=1, taken=1, target=32'h100 while stalled -> next pc=32'h100; taken=0, res_pc=32'h40 -> next pc=32'h44.
REQ-034 (FRONTEND_BPRED_EN) two taken resolutions res_pc=32'h20 target=32'h80 -> next fetch at 32'h20 gives pred_taken_o=1, pred_target_o=32'h80, next pc=32'h80.
REQ-035 flush_i=1 for 2 cycles -> addr_valid_o=0, issue_valid_o=0, pc held.
